// File: rtl/seq_shift_unit.sv
// -----------------------------------------------------------------------------
// seq_shift_unit
//   Multi-cycle shift/rotate execution unit. An operation is accepted on a
//   start edge, shifted by at most STEP bits per cycle, and the final value is
//   published on result together with a one-cycle done pulse.
//
//   Handshake: start is sampled only while busy is low (IDLE or DONE). An
//   accepted start latches mode/data_in/amount; done pulses high for exactly
//   one cycle when result has been updated; err accompanies done when the
//   accepted mode was illegal. start while busy is ignored.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   clear      synchronous active-high reset; aborts any operation in flight
//   start      operation request
//   mode       000 shr, 001 shra, 010 shl, 011 ror, 100 rol, others illegal
//   data_in    operand
//   amount     shift count 0..WIDTH-1
//   result     last completed result, held until the next completion
//   busy       high while shifting
//   done       one-cycle completion pulse
//   err        set when the last accepted mode was illegal
//   dbg_state  current FSM state (0 IDLE, 1 SHIFT, 2 DONE)
// -----------------------------------------------------------------------------
module seq_shift_unit #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] data_in,
    input  logic [AMT_W-1:0] amount,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // One extra bit so that STEP == WIDTH is representable in the counter.
    localparam int CNT_W = AMT_W + 1;
    localparam logic [CNT_W-1:0] STEP_C = CNT_W'(STEP);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [2:0]         mode_q, mode_d;
    logic [CNT_W-1:0]   left_q, left_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic [CNT_W-1:0]   k;
    logic [WIDTH-1:0]   shifted;
    logic               mode_illegal;

    // Shift the working value by k bits. Rotates use a doubled word so the
    // wrapped bits fall out of the shift naturally. Arithmetic right keeps
    // the sign bit of the working value, which is always the sign bit of the
    // latched operand because each partial shift replicates it.
    function automatic logic [WIDTH-1:0] shift_by(
        input logic [2:0]       m,
        input logic [WIDTH-1:0] w,
        input logic [CNT_W-1:0] kk
    );
        logic [2*WIDTH-1:0] dbl;
        logic [WIDTH-1:0]   r;
        dbl = {w, w};
        r   = w;
        case (m)
            3'b000: r = w >> kk;
            3'b001: r = $signed(w) >>> kk;
            3'b010: r = w << kk;
            3'b011: begin
                dbl = dbl >> kk;
                r   = dbl[WIDTH-1:0];
            end
            3'b100: begin
                dbl = dbl << kk;
                r   = dbl[2*WIDTH-1:WIDTH];
            end
            default: r = w;
        endcase
        return r;
    endfunction

    always_comb begin
        k            = (left_q >= STEP_C) ? STEP_C : left_q;
        shifted      = shift_by(mode_q, work_q, k);
        mode_illegal = (mode > 3'b100);

        state_d  = state_q;
        work_d   = work_q;
        mode_d   = mode_q;
        left_d   = left_q;
        result_d = result_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = err_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    mode_d = mode;
                    work_d = data_in;
                    left_d = {1'b0, amount};
                    err_d  = 1'b0;
                    if (mode_illegal) begin
                        state_d  = S_DONE;
                        result_d = data_in;
                        err_d    = 1'b1;
                        done_d   = 1'b1;
                    end else if (amount == '0) begin
                        state_d  = S_DONE;
                        result_d = data_in;
                        done_d   = 1'b1;
                    end else begin
                        state_d = S_SHIFT;
                        busy_d  = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                work_d = shifted;
                left_d = left_q - k;
                // Last slice: publish the final value only now so result
                // never shows intermediate shifts.
                if (left_q == k) begin
                    result_d = shifted;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    state_d  = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q  <= S_IDLE;
            work_q   <= '0;
            mode_q   <= '0;
            left_q   <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            mode_q   <= mode_d;
            left_q   <= left_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign result    = result_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule
